// File: rtl/afifo_wr_arbiter.sv
// Packet-granular round-robin arbiter in front of an async-FIFO write port.
// A grant is held for a whole packet, or until the beat limit forces a release.
module afifo_wr_arbiter #(
   parameter int NUM_REQ       = 4,
   parameter int DATA_WIDTH    = 8,
   parameter int MAX_PKT_BEATS = 1536,
   parameter int CNT_WIDTH     = 11
) (
   input  logic                          wr_clk_i,
   input  logic                          rstn_i,
   input  logic [NUM_REQ-1:0]            req_valid_i,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
   input  logic [NUM_REQ-1:0]            req_last_i,
   output logic [NUM_REQ-1:0]            req_ready_o,
   input  logic                          fifo_full_i,
   output logic                          fifo_wr_en_o,
   output logic [DATA_WIDTH:0]           fifo_wr_data_o,
   output logic [NUM_REQ-1:0]            grant_o,
   output logic                          busy_o,
   output logic                          pkt_done_o,
   output logic                          len_err_o,
   output logic [CNT_WIDTH-1:0]          beat_cnt_o
);

   localparam int PTR_W = $clog2(NUM_REQ);

   typedef enum logic {
      IDLE,
      XFER
   } state_t;

   state_t                 state_q, state_d;
   logic [NUM_REQ-1:0]     grant_q, grant_d;
   logic [PTR_W-1:0]       owner_q, owner_d;
   logic [PTR_W-1:0]       rr_q, rr_d;
   logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
   logic                   done_q, done_d;
   logic                   err_q, err_d;

   logic                   pick_found;
   logic [PTR_W-1:0]       pick_idx;
   logic [PTR_W:0]         cand;
   logic [DATA_WIDTH-1:0]  owner_data;
   logic                   owner_last;
   logic                   accept;
   logic                   at_limit;

   // Round-robin search: first valid requester at or above rr_q, wrapping.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      cand       = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = {1'b0, rr_q} + (PTR_W+1)'(i);
         if (cand >= (PTR_W+1)'(NUM_REQ)) begin
            cand = cand - (PTR_W+1)'(NUM_REQ);
         end
         if (!pick_found && req_valid_i[cand[PTR_W-1:0]]) begin
            pick_found = 1'b1;
            pick_idx   = cand[PTR_W-1:0];
         end
      end
   end

   always_comb begin
      owner_data = '0;
      owner_last = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (owner_q == PTR_W'(k)) begin
            owner_data = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
            owner_last = req_last_i[k];
         end
      end
   end

   // Ready is combinational from the registered full flag so the handshake closes in-cycle.
   assign req_ready_o    = (state_q == XFER && !fifo_full_i) ? grant_q : '0;
   assign accept         = |(req_valid_i & req_ready_o);
   assign fifo_wr_en_o   = accept;
   assign fifo_wr_data_o = {owner_last, owner_data};
   assign at_limit       = (cnt_q == CNT_WIDTH'(MAX_PKT_BEATS - 1));

   assign grant_o    = grant_q;
   assign busy_o     = (state_q == XFER);
   assign pkt_done_o = done_q;
   assign len_err_o  = err_q;
   assign beat_cnt_o = cnt_q;

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      owner_d = owner_q;
      rr_d    = rr_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (pick_found) begin
               state_d = XFER;
               grant_d = NUM_REQ'(1) << pick_idx;
               owner_d = pick_idx;
            end
         end
         XFER: begin
            if (accept) begin
               // A beat at the limit without last releases like a real last beat.
               if (owner_last || at_limit) begin
                  state_d = IDLE;
                  grant_d = '0;
                  cnt_d   = '0;
                  rr_d    = (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + PTR_W'(1);
                  done_d  = owner_last;
                  err_d   = ~owner_last;
               end else begin
                  cnt_d = cnt_q + CNT_WIDTH'(1);
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge wr_clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q <= IDLE;
         grant_q <= '0;
         owner_q <= '0;
         rr_q    <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         owner_q <= owner_d;
         rr_q    <= rr_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_afifo_wr_arbiter.sv
// Directed bench for afifo_wr_arbiter; requesters are modelled as packet sources
// that advance on each completed handshake.
module tb_afifo_wr_arbiter;

   localparam int NR   = 4;
   localparam int DW   = 8;
   localparam int MAXB = 4;
   localparam int CW   = 11;

   logic              wr_clk = 1'b0;
   logic              rstn   = 1'b0;
   logic [NR-1:0]     req_valid;
   logic [NR*DW-1:0]  req_data;
   logic [NR-1:0]     req_last;
   logic [NR-1:0]     req_ready;
   logic              fifo_full;
   logic              fifo_wr_en;
   logic [DW:0]       fifo_wr_data;
   logic [NR-1:0]     grant;
   logic              busy;
   logic              pkt_done;
   logic              len_err;
   logic [CW-1:0]     beat_cnt;

   int checks = 0;
   int errors = 0;

   bit          en_m   [NR];
   bit          hold_m [NR];
   int          total_m[NR];
   int          len_m  [NR];
   int          sent_m [NR];
   int          base_m [NR];
   int          step_m [NR];
   logic        full_m;
   logic [DW:0] wr_log[$];
   logic [NR-1:0] grant_seq[$];
   logic [NR-1:0] prev_grant;

   afifo_wr_arbiter #(
      .NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_PKT_BEATS(MAXB), .CNT_WIDTH(CW)
   ) dut (
      .wr_clk_i(wr_clk), .rstn_i(rstn),
      .req_valid_i(req_valid), .req_data_i(req_data), .req_last_i(req_last),
      .req_ready_o(req_ready), .fifo_full_i(fifo_full),
      .fifo_wr_en_o(fifo_wr_en), .fifo_wr_data_o(fifo_wr_data),
      .grant_o(grant), .busy_o(busy), .pkt_done_o(pkt_done),
      .len_err_o(len_err), .beat_cnt_o(beat_cnt)
   );

   always #5 wr_clk = ~wr_clk;

   // len_m of 0 means the source never raises last.
   task automatic drive_inputs();
      for (int k = 0; k < NR; k++) begin
         req_valid[k] = en_m[k] && !hold_m[k] && (sent_m[k] < total_m[k]);
         req_data[k*DW +: DW] = 8'(base_m[k] + step_m[k] * sent_m[k]);
         req_last[k] = (len_m[k] != 0) && (((sent_m[k] + 1) % len_m[k]) == 0);
      end
      fifo_full = full_m;
   endtask

   task automatic clear_model();
      for (int k = 0; k < NR; k++) begin
         en_m[k] = 1'b0; hold_m[k] = 1'b0; total_m[k] = 0; len_m[k] = 0;
         sent_m[k] = 0; base_m[k] = k * 16; step_m[k] = 1;
      end
      full_m = 1'b0;
      wr_log.delete();
      grant_seq.delete();
   endtask

   // Advance one clock; inputs change and outputs are sampled 1-2 ns after the edge.
   task automatic step();
      logic [NR-1:0] hs;
      hs = req_valid & req_ready;
      if (fifo_wr_en) begin
         wr_log.push_back(fifo_wr_data);
         checks++;
         if (fifo_full !== 1'b0) begin
            errors++;
            $display("[TB] FAIL write_while_full: fifo_full=%b while fifo_wr_en=1, required 0", fifo_full);
         end
      end
      @(posedge wr_clk); #1;
      for (int k = 0; k < NR; k++) if (hs[k]) sent_m[k]++;
      drive_inputs();
      #1;
      if (grant != '0 && prev_grant == '0) grant_seq.push_back(grant);
      prev_grant = grant;
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      clear_model();
      drive_inputs();
      repeat (2) @(posedge wr_clk);
      #1 rstn = 1'b1;
      #1 prev_grant = grant;
   endtask

   task automatic test_reset();
      clear_model();
      for (int k = 0; k < NR; k++) begin en_m[k] = 1'b1; total_m[k] = 1; len_m[k] = 1; end
      drive_inputs();
      repeat (2) @(posedge wr_clk);
      #2;
      checks++; if (grant !== 4'h0) begin errors++; $display("[TB] FAIL reset grant: got %b required 0000", grant); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset busy: got %b required 0", busy); end
      checks++; if (req_ready !== 4'h0) begin errors++; $display("[TB] FAIL reset ready: got %b required 0000", req_ready); end
      checks++; if (fifo_wr_en !== 1'b0) begin errors++; $display("[TB] FAIL reset wr_en: got %b required 0", fifo_wr_en); end
      checks++; if (pkt_done !== 1'b0 || len_err !== 1'b0) begin errors++; $display("[TB] FAIL reset pulses: got %b%b required 00", pkt_done, len_err); end
      checks++; if (beat_cnt !== 11'd0) begin errors++; $display("[TB] FAIL reset beat_cnt: got %0d required 0", beat_cnt); end
      rstn = 1'b1;
      #1 prev_grant = grant;
      checks++; if (grant !== 4'h0) begin errors++; $display("[TB] FAIL reset idle grant: got %b required 0000", grant); end
      step();
      checks++; if (grant !== 4'b0001) begin errors++; $display("[TB] FAIL reset first grant: got %b required 0001", grant); end
      checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL reset first busy: got %b required 1", busy); end
   endtask

   task automatic test_single_packet();
      int eg [7] = '{0, 1, 1, 1, 0, 1, 1};
      int ew [7] = '{0, 1, 1, 1, 0, 1, 1};
      int ed [7] = '{0, 'h011, 'h022, 'h133, 0, 'h044, 'h055};
      int ec [7] = '{0, 0, 1, 2, 0, 0, 1};
      int en [7] = '{0, 0, 0, 0, 1, 0, 0};
      do_reset();
      en_m[0] = 1'b1; total_m[0] = 6; len_m[0] = 3; base_m[0] = 'h11; step_m[0] = 'h11;
      drive_inputs(); #1;
      for (int c = 0; c < 7; c++) begin
         if (c > 0) step();
         checks++; if (grant !== 4'(eg[c])) begin errors++; $display("[TB] FAIL single c%0d grant: got %b required %b", c, grant, 4'(eg[c])); end
         checks++; if (fifo_wr_en !== 1'(ew[c])) begin errors++; $display("[TB] FAIL single c%0d wr_en: got %b required %b", c, fifo_wr_en, 1'(ew[c])); end
         if (ew[c] != 0) begin
            checks++; if (fifo_wr_data !== 9'(ed[c])) begin errors++; $display("[TB] FAIL single c%0d wr_data: got %h required %h", c, fifo_wr_data, 9'(ed[c])); end
         end
         checks++; if (beat_cnt !== 11'(ec[c])) begin errors++; $display("[TB] FAIL single c%0d beat_cnt: got %0d required %0d", c, beat_cnt, ec[c]); end
         checks++; if (pkt_done !== 1'(en[c])) begin errors++; $display("[TB] FAIL single c%0d pkt_done: got %b required %b", c, pkt_done, 1'(en[c])); end
      end
   endtask

   task automatic test_round_robin();
      int exp_g [5]  = '{1, 2, 4, 8, 1};
      int exp_d [10] = '{'h000, 'h101, 'h010, 'h111, 'h020, 'h121, 'h030, 'h131, 'h002, 'h103};
      do_reset();
      for (int k = 0; k < NR; k++) begin en_m[k] = 1'b1; total_m[k] = 2; len_m[k] = 2; end
      total_m[0] = 4;
      drive_inputs(); #1;
      repeat (20) step();
      checks++; if (grant_seq.size() != 5) begin errors++; $display("[TB] FAIL rr grant count: got %0d required 5", grant_seq.size()); end
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (i >= grant_seq.size()) begin errors++; $display("[TB] FAIL rr grant %0d: got none required %b", i, 4'(exp_g[i])); end
         else if (grant_seq[i] !== 4'(exp_g[i])) begin errors++; $display("[TB] FAIL rr grant %0d: got %b required %b", i, grant_seq[i], 4'(exp_g[i])); end
      end
      checks++; if (wr_log.size() != 10) begin errors++; $display("[TB] FAIL rr write count: got %0d required 10", wr_log.size()); end
      for (int i = 0; i < 10; i++) begin
         checks++;
         if (i >= wr_log.size()) begin errors++; $display("[TB] FAIL rr stream %0d: got none required %h", i, 9'(exp_d[i])); end
         else if (wr_log[i] !== 9'(exp_d[i])) begin errors++; $display("[TB] FAIL rr stream %0d: got %h required %h", i, wr_log[i], 9'(exp_d[i])); end
      end
   endtask

   task automatic test_fifo_full();
      int eg [11] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
      int er [11] = '{0, 1, 1, 0, 0, 0, 0, 0, 1, 1, 0};
      int ew [11] = '{0, 1, 1, 0, 0, 0, 0, 0, 1, 1, 0};
      int ed [11] = '{0, 'h000, 'h001, 0, 0, 0, 0, 0, 'h002, 'h103, 0};
      int ec [11] = '{0, 0, 1, 2, 2, 2, 2, 2, 2, 3, 0};
      int en [11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
      do_reset();
      en_m[0] = 1'b1; total_m[0] = 4; len_m[0] = 4;
      drive_inputs(); #1;
      for (int c = 0; c < 11; c++) begin
         if (c > 0) step();
         checks++; if (grant !== 4'(eg[c])) begin errors++; $display("[TB] FAIL full c%0d grant: got %b required %b", c, grant, 4'(eg[c])); end
         checks++; if (req_ready !== 4'(er[c])) begin errors++; $display("[TB] FAIL full c%0d ready: got %b required %b", c, req_ready, 4'(er[c])); end
         checks++; if (fifo_wr_en !== 1'(ew[c])) begin errors++; $display("[TB] FAIL full c%0d wr_en: got %b required %b", c, fifo_wr_en, 1'(ew[c])); end
         if (ew[c] != 0) begin
            checks++; if (fifo_wr_data !== 9'(ed[c])) begin errors++; $display("[TB] FAIL full c%0d wr_data: got %h required %h", c, fifo_wr_data, 9'(ed[c])); end
         end
         checks++; if (beat_cnt !== 11'(ec[c])) begin errors++; $display("[TB] FAIL full c%0d beat_cnt: got %0d required %0d", c, beat_cnt, ec[c]); end
         checks++; if (pkt_done !== 1'(en[c])) begin errors++; $display("[TB] FAIL full c%0d pkt_done: got %b required %b", c, pkt_done, 1'(en[c])); end
         if (c == 2) full_m = 1'b1;
         if (c == 7) full_m = 1'b0;
      end
   endtask

   task automatic test_len_limit();
      int eg [11] = '{0, 2, 2, 2, 2, 0, 4, 0, 2, 2, 2};
      int ew [11] = '{0, 1, 1, 1, 1, 0, 1, 0, 1, 1, 0};
      int ed [11] = '{0, 'h010, 'h011, 'h012, 'h013, 0, 'h120, 0, 'h014, 'h015, 0};
      int ec [11] = '{0, 0, 1, 2, 3, 0, 0, 0, 0, 1, 2};
      int en [11] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
      int ee [11] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
      do_reset();
      en_m[1] = 1'b1; total_m[1] = 6; len_m[1] = 0;
      en_m[2] = 1'b1; total_m[2] = 1; len_m[2] = 1;
      drive_inputs(); #1;
      for (int c = 0; c < 11; c++) begin
         if (c > 0) step();
         checks++; if (grant !== 4'(eg[c])) begin errors++; $display("[TB] FAIL len c%0d grant: got %b required %b", c, grant, 4'(eg[c])); end
         checks++; if (fifo_wr_en !== 1'(ew[c])) begin errors++; $display("[TB] FAIL len c%0d wr_en: got %b required %b", c, fifo_wr_en, 1'(ew[c])); end
         if (ew[c] != 0) begin
            checks++; if (fifo_wr_data !== 9'(ed[c])) begin errors++; $display("[TB] FAIL len c%0d wr_data: got %h required %h", c, fifo_wr_data, 9'(ed[c])); end
         end
         checks++; if (beat_cnt !== 11'(ec[c])) begin errors++; $display("[TB] FAIL len c%0d beat_cnt: got %0d required %0d", c, beat_cnt, ec[c]); end
         checks++; if (pkt_done !== 1'(en[c])) begin errors++; $display("[TB] FAIL len c%0d pkt_done: got %b required %b", c, pkt_done, 1'(en[c])); end
         checks++; if (len_err !== 1'(ee[c])) begin errors++; $display("[TB] FAIL len c%0d len_err: got %b required %b", c, len_err, 1'(ee[c])); end
      end
   endtask

   task automatic test_owner_hold();
      do_reset();
      en_m[0] = 1'b1; total_m[0] = 3; len_m[0] = 3;
      en_m[2] = 1'b1; total_m[2] = 1; len_m[2] = 1;
      drive_inputs(); #1;
      step();
      checks++; if (grant !== 4'b0001 || fifo_wr_data !== 9'h000) begin errors++; $display("[TB] FAIL hold start: got grant %b data %h required 0001 000", grant, fifo_wr_data); end
      hold_m[0] = 1'b1;
      for (int c = 0; c < 10; c++) begin
         step();
         checks++; if (grant !== 4'b0001) begin errors++; $display("[TB] FAIL hold c%0d grant: got %b required 0001", c, grant); end
         checks++; if (fifo_wr_en !== 1'b0) begin errors++; $display("[TB] FAIL hold c%0d wr_en: got %b required 0", c, fifo_wr_en); end
         checks++; if (beat_cnt !== 11'd1) begin errors++; $display("[TB] FAIL hold c%0d beat_cnt: got %0d required 1", c, beat_cnt); end
      end
      hold_m[0] = 1'b0;
      step();
      checks++; if (fifo_wr_en !== 1'b1 || fifo_wr_data !== 9'h001) begin errors++; $display("[TB] FAIL hold resume: got wr_en %b data %h required 1 001", fifo_wr_en, fifo_wr_data); end
      step();
      checks++; if (fifo_wr_en !== 1'b1 || fifo_wr_data !== 9'h102) begin errors++; $display("[TB] FAIL hold last: got wr_en %b data %h required 1 102", fifo_wr_en, fifo_wr_data); end
      step();
      checks++; if (grant !== 4'h0 || pkt_done !== 1'b1) begin errors++; $display("[TB] FAIL hold release: got grant %b done %b required 0000 1", grant, pkt_done); end
      step();
      checks++; if (grant !== 4'b0100 || fifo_wr_data !== 9'h120) begin errors++; $display("[TB] FAIL hold next owner: got grant %b data %h required 0100 120", grant, fifo_wr_data); end
   endtask

   task automatic test_mid_reset();
      do_reset();
      en_m[0] = 1'b1; total_m[0] = 1; len_m[0] = 1;
      en_m[1] = 1'b1; total_m[1] = 4; len_m[1] = 4;
      drive_inputs(); #1;
      repeat (4) step();
      checks++; if (grant !== 4'b0010 || fifo_wr_data !== 9'h011 || beat_cnt !== 11'd1) begin
         errors++; $display("[TB] FAIL mreset 2nd beat: got grant %b data %h cnt %0d required 0010 011 1", grant, fifo_wr_data, beat_cnt);
      end
      rstn = 1'b0;
      #1;
      checks++; if (grant !== 4'h0) begin errors++; $display("[TB] FAIL mreset grant: got %b required 0000", grant); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL mreset busy: got %b required 0", busy); end
      checks++; if (req_ready !== 4'h0) begin errors++; $display("[TB] FAIL mreset ready: got %b required 0000", req_ready); end
      checks++; if (fifo_wr_en !== 1'b0) begin errors++; $display("[TB] FAIL mreset wr_en: got %b required 0", fifo_wr_en); end
      checks++; if (beat_cnt !== 11'd0) begin errors++; $display("[TB] FAIL mreset beat_cnt: got %0d required 0", beat_cnt); end
      for (int k = 0; k < NR; k++) sent_m[k] = 0;
      total_m[0] = 4; len_m[0] = 4;
      drive_inputs();
      @(posedge wr_clk); #1;
      rstn = 1'b1;
      #1 prev_grant = grant;
      checks++; if (grant !== 4'h0) begin errors++; $display("[TB] FAIL mreset idle: got %b required 0000", grant); end
      step();
      checks++; if (grant !== 4'b0001 || fifo_wr_data !== 9'h000) begin errors++; $display("[TB] FAIL mreset restart: got grant %b data %h required 0001 000", grant, fifo_wr_data); end
   endtask

   initial begin
      clear_model();
      drive_inputs();
      $display("[TB] starting afifo_wr_arbiter bench");
      test_reset();
      test_single_packet();
      test_round_robin();
      test_fifo_full();
      test_len_limit();
      test_owner_hold();
      test_mid_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/afifo_wr_arbiter.md
Name: afifo_wr_arbiter

Overview:
- Packet-granular round-robin arbiter sharing one async-FIFO write port (wr_clk_i domain) among NUM_REQ requesters, e.g. per-queue TSN frame sources.
- Holds a grant for a whole packet (until last beat) so packets never interleave in the FIFO.
- Throttles on the FIFO's registered full flag.
- Enforces a maximum packet length and reports per-grant statistics.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 8, payload width per beat.
- MAX_PKT_BEATS, 1536, beats allowed per packet before forced release.
- CNT_WIDTH, 11, width of beat counter; must hold MAX_PKT_BEATS.

Ports:
- wr_clk_i  in  1  write-domain clock.
- rstn_i  in  1  asynchronous active-low reset.
- req_valid_i  in  NUM_REQ  per-requester beat valid.
- req_data_i  in  NUM_REQ*DATA_WIDTH  packed beats; requester k at [k*DATA_WIDTH +: DATA_WIDTH].
- req_last_i  in  NUM_REQ  per-requester last-beat flag.
- req_ready_o  out  NUM_REQ  per-requester beat accept.
- fifo_full_i  in  1  FIFO write-side full flag.
- fifo_wr_en_o  out  1  FIFO write enable.
- fifo_wr_data_o  out  DATA_WIDTH+1  {last, data} written to FIFO.
- grant_o  out  NUM_REQ  one-hot current owner; 0 when idle.
- busy_o  out  1  high in XFER state.
- pkt_done_o  out  1  one-cycle pulse on an accepted last beat.
- len_err_o  out  1  one-cycle pulse on forced release.
- beat_cnt_o  out  CNT_WIDTH  beats accepted in the current packet.

Behaviour:
- Reset (async, rstn_i low):
  - state=IDLE, grant_o=0, rr pointer=0, beat_cnt_o=0.
  - All pulses 0, req_ready_o=0, fifo_wr_en_o=0.
- States: IDLE, XFER.
- IDLE:
  - If any req_valid_i is high, pick the first set requester searching from rr pointer upward, wrapping modulo NUM_REQ.
  - Register the pick into grant_o; go to XFER next cycle.
  - No data is accepted in the IDLE cycle (1-cycle arbitration latency).
- XFER, owner g:
  - req_ready_o[g] = ~fifo_full_i. Combinational, so the handshake completes the same cycle.
  - All other req_ready_o bits are 0.
  - Beat accepted when req_valid_i[g] & req_ready_o[g].
  - fifo_wr_en_o = accepted beat.
  - fifo_wr_data_o = {req_last_i[g], req_data_g}. It is the combinational mux of the owner and only meaningful when fifo_wr_en_o is high.
  - fifo_wr_en_o is never high while fifo_full_i is high.
  - Each accepted beat increments beat_cnt_o.
- Accepted beat with last=1:
  - pkt_done_o pulses the following cycle.
  - rr pointer <= (g+1) mod NUM_REQ; grant_o <= 0; beat_cnt_o <= 0; state -> IDLE.
- Length limit:
  - Accepted beat with last=0 while beat_cnt_o == MAX_PKT_BEATS-1: release exactly as if last, except len_err_o pulses instead of pkt_done_o.
  - The FIFO receives that beat with last=0; downstream handles the truncation.
  - Further beats from that requester re-arbitrate as a new packet.
- Owner drops valid mid-packet: grant is held indefinitely. There is no timeout on idle valid.
- fifo_full_i high for any duration: grant held, no beats lost, counter frozen.
- Single requester continuously valid: gets back-to-back packets with one IDLE cycle between them.
- Simultaneous requests: strict round-robin fairness. A requester waits at most NUM_REQ-1 packets.
- A requester whose valid rises during another's packet is considered only at the next IDLE cycle.
- Mid-packet reset: all state cleared immediately. The partially written packet in the FIFO is the owner's responsibility; no recovery beat is written.
- Widths: beat_cnt_o saturates logically via the release rule and never wraps.

Test Plan:
- Single requester 0 sends a 3-beat packet (data 0x11, 0x22, 0x33, last on 3rd), FIFO not full:
  - grant_o=0001 one cycle after valid.
  - 3 consecutive fifo_wr_en_o with the data above and last=1 on 0x33.
  - pkt_done_o pulse, then grant_o=0.
- Requesters 0..3 all valid with 2-beat packets from reset:
  - Grant order 0,1,2,3,0.
  - No interleaving of beats within the FIFO stream.
- Owner mid-packet, fifo_full_i held high 5 cycles after the 2nd beat:
  - req_ready_o and fifo_wr_en_o low for those 5 cycles.
  - beat_cnt_o stays 2; resumes with the 3rd beat when full drops.
- MAX_PKT_BEATS=4, requester 1 sends 6 beats without last:
  - 4 beats written, the 4th with last=0.
  - len_err_o pulse, grant released.
  - Next grant goes to requester 2 if valid, else back to 1 for the remaining 2 beats.
- Reset asserted on the 2nd beat of a 4-beat packet:
  - All outputs go to reset values asynchronously.
  - After release, arbitration restarts from requester 0.
- Owner deasserts valid for 10 cycles mid-packet while requester 2 is valid:
  - grant_o unchanged and no writes during those 10 cycles.
  - Requester 2 is served only after the owner's last beat.
